cic_stream_sink: RTL
====================

// Module: cic_stream_sink
// PURPOSE
//  Consumer end of the CIC filter output interface (Yout plus single-cycle rdy strobe, no backpressure).
//  Removes CIC bit growth by an arithmetic right shift with rounding, then saturates to OUT_WIDTH.
//  Buffers results in a FIFO and presents a valid/ready stream to the downstream pulse-compression logic.
//  Never stalls the CIC; if the FIFO is full when a sample is due, that sample is dropped and flagged.
// PARAMETERS
//  IN_WIDTH   22  width of CIC output word (signed)
//  OUT_WIDTH  16  width of delivered sample (signed); OUT_WIDTH <= IN_WIDTH
//  SHIFT      6   right shift removing CIC gain; 0 <= SHIFT < IN_WIDTH
//  DEPTH      8   FIFO entries; power of 2, >= 2
// PORTS
//  clk        in   1                  clock
//  rst        in   1                  reset, asynchronous, active-low
//  din        in   IN_WIDTH           CIC output word (Yout), signed
//  din_valid  in   1                  CIC rdy strobe; din sampled when high
//  m_data     out  OUT_WIDTH          head-of-FIFO sample, signed
//  m_valid    out  1                  m_data valid
//  m_ready    in   1                  downstream accepts; transfer = m_valid & m_ready
//  level      out  $clog2(DEPTH)+1    FIFO occupancy, 0..DEPTH
//  overflow   out  1                  sticky: a sample was dropped on a full FIFO
//  sat_flag   out  1                  sticky: a sample was saturated
//  clr        in   1                  synchronous clear of overflow and sat_flag
// BEHAVIOUR
//  Reset (rst=0, async): pipeline valids, FIFO pointers, level, m_valid, overflow, sat_flag, m_data -> 0.
//  S1 (registered on din_valid):
//   - r = (din + 2^(SHIFT-1)) >>> SHIFT, computed in IN_WIDTH+1 bits so there is no wrap.
//   - Rounding is round-half-up toward +inf. When SHIFT = 0, r = din.
//  S2 (registered): saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; s2_sat = value was clipped.
//  Write: a valid S2 word writes the FIFO at the next edge.
//  Latency: din_valid at edge N; with the FIFO empty, m_valid=1 and m_data valid after edge N+3.
//  Throughput: one sample per clock sustained.
//  FIFO: first-word-fall-through; m_data holds the head entry; m_valid = (level != 0).
//  Holding rule: m_data/m_valid must stay stable while m_valid & !m_ready.
//  Full handling:
//   - Write while level == DEPTH and no pop in the same cycle: word dropped, overflow <= 1.
//   - Other entries and the pointers are unchanged.
//  Simultaneous pop and write:
//   - At full: write accepted, level stays DEPTH, no overflow.
//   - At empty: a pop cannot occur (m_valid=0), so the write proceeds and level goes 0 -> 1.
//  Pointers: wrap modulo DEPTH; level is an up/down counter and never exceeds DEPTH or goes below 0.
//  sat_flag <= 1 when a saturated word is written to the FIFO. Dropped words do not set sat_flag.
//  clr: overflow and sat_flag <= 0. If a set event occurs in the same cycle, set wins.
//  Reset mid-operation: all in-flight S1/S2 words and FIFO contents are discarded; no partial output.
// CONFIGURATION
//  CIC_SINK_CONV_ROUND_EN defined:
//   - S1 uses convergent rounding (round half to even) for SHIFT >= 1.
//   - An exact half rounds to the even result; all other values match round-half-up.
//  Not defined: round-half-up as above.
//  Latency and all other behaviour are identical in both builds.
// TESTING (IN_WIDTH=22, OUT_WIDTH=16, SHIFT=6, DEPTH=8)
//  1. Rounding:
//     - din=64, 96, 160 strobed, m_ready=1 -> m_data = 1, 2, 3.
//     - With CIC_SINK_CONV_ROUND_EN: 1, 2, 2.
//     - First m_valid appears 3 edges after the first strobe.
//  2. Saturation:
//     - din=0x1FFFE0 -> 0x7FFF, sat_flag=1.
//     - After clr, din=0x200000 -> 0x8000, sat_flag stays 0.
//  3. Backpressure/overflow:
//     - m_ready=0, 10 strobes din=64*k (k=1..10) -> level=8, overflow=1.
//     - Then m_ready=1 drains exactly 1..8 in order, level -> 0.
//  4. Full with simultaneous pop:
//     - FIFO full, pulse m_ready for one cycle while a strobe arrives -> level stays 8.
//     - overflow stays 0; order is preserved.
//  5. Reset mid-stream:
//     - rst low for 1 cycle with level=5 and 2 words in S1/S2.
//     - Result: m_valid=0, level=0, flags=0, and no stale word ever emerges.
//  6. Back-to-back strobes every cycle with m_ready=1 -> one output per cycle, level <= 1, no overflow.

Source files
------------

// File: rtl/cic_stream_sink.sv
// cic_stream_sink: consumer end of the CIC output interface.
// Rounds away the CIC bit growth (arithmetic right shift), saturates to
// OUT_WIDTH and buffers the results in a first-word-fall-through FIFO that
// feeds a valid/ready stream. The CIC is never stalled: a sample that meets a
// full FIFO is dropped and reported through the sticky overflow flag.
// Build option: define CIC_SINK_CONV_ROUND_EN for convergent (half-to-even)
// rounding; without it rounding is round-half-up.
module cic_stream_sink #(
    parameter int IN_WIDTH  = 22,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 6,
    parameter int DEPTH     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IN_WIDTH-1:0]     din,
    input  logic                    din_valid,
    output logic [OUT_WIDTH-1:0]    m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    sat_flag,
    input  logic                    clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    // One guard bit keeps the rounding addition from wrapping.
    localparam int RW = IN_WIDTH + 1;

    localparam logic [LW-1:0]        FULL_LEVEL = LW'(DEPTH);
    localparam logic signed [RW-1:0] SAT_MAX    = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN    = ~SAT_MAX;

    logic signed [RW-1:0]  din_ext;
    logic signed [RW-1:0]  rnd;

    logic                  s1_valid_q, s1_valid_d;
    logic signed [RW-1:0]  s1_data_q,  s1_data_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [OUT_WIDTH-1:0]  s2_data_q,  s2_data_d;
    logic                  s2_sat_q,   s2_sat_d;

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q,  level_d;
    logic                  overflow_q, overflow_d;
    logic                  sat_flag_q, sat_flag_d;

    logic [OUT_WIDTH-1:0]  mem [DEPTH];

    logic                  full;
    logic                  pop;
    logic                  wr_en;
    logic                  drop;

    assign din_ext = {din[IN_WIDTH-1], din};

    // Rounding shifter; a zero shift passes the word straight through.
    generate
        if (SHIFT == 0) begin : g_no_shift
            assign rnd = din_ext;
        end else begin : g_shift
            localparam logic [RW-1:0] HALF = RW'(1) << (SHIFT - 1);
            localparam logic [RW-1:0] MASK = (RW'(1) << SHIFT) - RW'(1);
            logic signed [RW-1:0] sum;
            logic signed [RW-1:0] up;
            assign sum = din_ext + HALF;
            assign up  = sum >>> SHIFT;
`ifdef CIC_SINK_CONV_ROUND_EN
            // An exact half rounded up lands on an odd value: step back to the even one.
            logic tie;
            assign tie = ((din_ext & MASK) == HALF);
            assign rnd = (tie && up[0]) ? (up - RW'(1)) : up;
`else
            assign rnd = up;
`endif
        end
    endgenerate

    // S1 captures the rounded word, S2 clips it to the output range.
    always_comb begin
        s1_valid_d = din_valid;
        s1_data_d  = din_valid ? rnd : s1_data_q;
        s2_valid_d = s1_valid_q;
        s2_data_d  = s2_data_q;
        s2_sat_d   = s2_sat_q;
        if (s1_valid_q) begin
            if (s1_data_q > SAT_MAX) begin
                s2_data_d = SAT_MAX[OUT_WIDTH-1:0];
                s2_sat_d  = 1'b1;
            end else if (s1_data_q < SAT_MIN) begin
                s2_data_d = SAT_MIN[OUT_WIDTH-1:0];
                s2_sat_d  = 1'b1;
            end else begin
                s2_data_d = s1_data_q[OUT_WIDTH-1:0];
                s2_sat_d  = 1'b0;
            end
        end
    end

    // FIFO control: a pop in the same cycle makes room for a write at full.
    always_comb begin
        full       = (level_q == FULL_LEVEL);
        pop        = m_valid & m_ready;
        wr_en      = s2_valid_q & (~full | pop);
        drop       = s2_valid_q & full & ~pop;
        wr_ptr_d   = wr_en ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d   = pop ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        level_d    = level_q;
        if (wr_en && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!wr_en && pop) begin
            level_d = level_q - LW'(1);
        end
        // Set events take priority over a clear in the same cycle.
        overflow_d = clr ? 1'b0 : overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end
        sat_flag_d = clr ? 1'b0 : sat_flag_q;
        if (wr_en && s2_sat_q) begin
            sat_flag_d = 1'b1;
        end
    end

    // State registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sat_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            sat_flag_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_sat_q   <= s2_sat_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            sat_flag_q <= sat_flag_d;
        end
    end

    // Storage array; contents need no reset because level gates the output.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= s2_data_q;
        end
    end

    assign m_valid  = (level_q != '0);
    assign m_data   = m_valid ? mem[rd_ptr_q] : '0;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign sat_flag = sat_flag_q;

endmodule
